// File: rtl/pcs_chk_pkg.sv
// rtl/pcs_chk_pkg.sv - shared types and constants for the 257b receive checker
package pcs_chk_pkg;

  typedef enum logic [1:0] {
    LOCK_INIT = 2'd0,
    LOCK_TEST = 2'd1,
    LOCKED    = 2'd2
  } lock_state_t;

  localparam int SCR_TAP_A = 39;
  localparam int SCR_TAP_B = 58;
  localparam int LOCK_WINDOW = 64;

  localparam logic       HDR_DATA      = 1'b1;
  localparam logic [3:0] ILLEGAL_FLAGS = 4'hF;

  // A control-carrying block whose flags claim "no control block" is malformed.
  function automatic logic hdr_is_bad(input logic [4:0] hdr);
    return (hdr[0] != HDR_DATA) && (hdr[4:1] == ILLEGAL_FLAGS);
  endfunction

endpackage

// File: rtl/pcs_descrambler_257.sv
// rtl/pcs_descrambler_257.sv - self-synchronizing 1 + x^39 + x^58 descrambler, one block per cycle
module pcs_descrambler_257
  import pcs_chk_pkg::*;
#(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic [WIDTH-1:0] scr_in,
  output logic [WIDTH-1:0] data_out
);

  logic [SCR_TAP_B-1:0]       state;
  logic [WIDTH+SCR_TAP_B-1:0] hist;

  // hist[k] is scrambled bit k counted from 58 bits before this block's first bit
  assign hist = {scr_in, state};

  assign data_out = hist[WIDTH+SCR_TAP_B-1:SCR_TAP_B]
                  ^ hist[WIDTH+SCR_TAP_B-1-SCR_TAP_A:SCR_TAP_B-SCR_TAP_A]
                  ^ hist[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= '0;
    end else if (advance) begin
      state <= scr_in[WIDTH-1:WIDTH-SCR_TAP_B];
    end
  end

endmodule

// File: rtl/pcs_257b_rx_checker.sv
// rtl/pcs_257b_rx_checker.sv - descrambles 257b blocks, checks headers, tracks lock and statistics
module pcs_257b_rx_checker
  import pcs_chk_pkg::*;
#(
  parameter int TRANSCODER_WIDTH     = 257,
  parameter int TRANSCODER_BLOCKS    = 4,
  parameter int TRANSCODER_HDR_WIDTH = 4,
  parameter int LOCK_GOOD_CNT        = 64,
  parameter int LOCK_BAD_CNT         = 16,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                        clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  input  logic [TRANSCODER_WIDTH-1:0] i_scrambler,
  input  logic                        i_clr_cnt,
  output logic                        o_valid,
  output logic [TRANSCODER_WIDTH-1:0] o_data,
  output logic                        o_hdr_err,
  output logic                        o_lock,
  output logic [CNT_WIDTH-1:0]        o_block_cnt,
  output logic [CNT_WIDTH-1:0]        o_err_cnt
);

  localparam int GW = $clog2(LOCK_GOOD_CNT);
  localparam int BW = $clog2(LOCK_BAD_CNT);
  localparam int WW = $clog2(LOCK_WINDOW);

  if ((TRANSCODER_WIDTH != TRANSCODER_BLOCKS * 64 + 1) ||
      (TRANSCODER_HDR_WIDTH != TRANSCODER_BLOCKS)) begin : g_bad_geometry
    $error("pcs_257b_rx_checker: inconsistent transcoder geometry");
  end

  logic [TRANSCODER_WIDTH-1:0] desc;
  logic                        synced;
  logic                        hdr_bad;
  logic                        blk_ev;
  lock_state_t                 state;
  logic [GW-1:0]               good_cnt;
  logic [BW-1:0]               bad_cnt;
  logic [WW-1:0]               win_cnt;

  pcs_descrambler_257 #(.WIDTH(TRANSCODER_WIDTH - 1)) u_descrambler (
    .clk      (clk),
    .rst_n    (i_rst_n),
    .advance  (i_valid),
    .scr_in   (i_scrambler[TRANSCODER_WIDTH-1:1]),
    .data_out (desc[TRANSCODER_WIDTH-1:1])
  );

  assign desc[0] = i_scrambler[0];
  assign hdr_bad = hdr_is_bad(desc[TRANSCODER_HDR_WIDTH:0]);
  // The first block after reset is descrambled from a zeroed history, so it is never judged.
  assign blk_ev  = i_valid && synced;
  assign o_lock  = (state == LOCKED);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      synced <= 1'b0;
    end else if (i_valid) begin
      synced <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_hdr_err <= 1'b0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_data    <= desc;
        o_hdr_err <= hdr_bad && synced;
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= LOCK_INIT;
      good_cnt <= '0;
      bad_cnt  <= '0;
      win_cnt  <= '0;
    end else if (blk_ev) begin
      case (state)
        LOCK_INIT: begin
          // The block that leaves INIT already counts toward the good run.
          state    <= LOCK_TEST;
          good_cnt <= hdr_bad ? '0 : GW'(1);
          bad_cnt  <= '0;
          win_cnt  <= '0;
        end
        LOCK_TEST: begin
          if (hdr_bad) begin
            good_cnt <= '0;
          end else if (good_cnt == GW'(LOCK_GOOD_CNT - 1)) begin
            state    <= LOCKED;
            good_cnt <= '0;
            bad_cnt  <= '0;
            win_cnt  <= '0;
          end else begin
            good_cnt <= good_cnt + 1'b1;
          end
        end
        LOCKED: begin
          if (hdr_bad && (bad_cnt == BW'(LOCK_BAD_CNT - 1))) begin
            state    <= LOCK_TEST;
            good_cnt <= '0;
            bad_cnt  <= '0;
            win_cnt  <= '0;
          end else if (win_cnt == WW'(LOCK_WINDOW - 1)) begin
            win_cnt <= '0;
            bad_cnt <= '0;
          end else begin
            win_cnt <= win_cnt + 1'b1;
            if (hdr_bad) begin
              bad_cnt <= bad_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= LOCK_INIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_block_cnt <= '0;
      o_err_cnt   <= '0;
    end else if (i_clr_cnt) begin
      o_block_cnt <= '0;
      o_err_cnt   <= '0;
    end else if (blk_ev && o_lock) begin
      if (o_block_cnt != '1) begin
        o_block_cnt <= o_block_cnt + 1'b1;
      end
      if (hdr_bad && (o_err_cnt != '1)) begin
        o_err_cnt <= o_err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pcs_257b_rx_checker.sv
// tb/tb_pcs_257b_rx_checker.sv - scoreboard bench for the 257b receive checker
module tb_pcs_257b_rx_checker;

  localparam int W = 257;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_valid;
  logic [W-1:0] i_scrambler;
  logic         i_clr_cnt;
  logic         o_valid;
  logic [W-1:0] o_data;
  logic         o_hdr_err;
  logic         o_lock;
  logic [31:0]  o_block_cnt;
  logic [31:0]  o_err_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         hdr_err;
    logic         chk_data;
  } exp_t;

  exp_t         sbq[$];
  exp_t         mon_e;
  logic [57:0]  tx_sh;
  logic         tb_synced;
  logic [W-1:0] last_payload;

  always #5 clk = ~clk;

  pcs_257b_rx_checker dut (
    .clk         (clk),
    .i_rst_n     (rst_n),
    .i_valid     (i_valid),
    .i_scrambler (i_scrambler),
    .i_clr_cnt   (i_clr_cnt),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_hdr_err   (o_hdr_err),
    .o_lock      (o_lock),
    .o_block_cnt (o_block_cnt),
    .o_err_cnt   (o_err_cnt)
  );

  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow: output seen with no expected block queued");
      end else begin
        mon_e = sbq.pop_front();
        if (o_hdr_err !== mon_e.hdr_err) begin
          failures++;
          $display("FAIL sb_hdr_err: got %b want %b", o_hdr_err, mon_e.hdr_err);
        end
        if (mon_e.chk_data) begin
          checks++;
          if (o_data !== mon_e.data) begin
            failures++;
            $display("FAIL sb_data: got %h want %h", o_data, mon_e.data);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mk_block(input int kind);
    logic [W-1:0] v;
    for (int k = 0; k < W; k++) v[k] = 1'($urandom_range(0, 1));
    case (kind)
      0: v[0] = 1'b1;
      1: if (v[0] == 1'b0 && v[4:1] == 4'hF) v[4:1] = 4'h3;
      default: begin
        v[0]   = 1'b0;
        v[4:1] = 4'hF;
      end
    endcase
    return v;
  endfunction

  // Reference scrambler: s[i] = d[i] ^ s[i-39] ^ s[i-58], header bit untouched.
  task automatic send(input logic [W-1:0] pay);
    logic [W-1:0] scr;
    logic         b;
    scr[0] = pay[0];
    for (int i = 1; i < W; i++) begin
      b      = pay[i] ^ tx_sh[38] ^ tx_sh[57];
      scr[i] = b;
      tx_sh  = {tx_sh[56:0], b};
    end
    sbq.push_back('{pay, tb_synced && !pay[0] && (pay[4:1] == 4'hF), tb_synced});
    tb_synced    = 1'b1;
    last_payload = pay;
    i_scrambler  = scr;
    i_valid      = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic feed(input int n, input int kind);
    for (int k = 0; k < n; k++) send(mk_block(kind));
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    i_valid   = 1'b0;
    i_clr_cnt = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    tb_synced = 1'b0;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    i_valid     = 1'b1;
    i_clr_cnt   = 1'b0;
    i_scrambler = mk_block(1);
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (o_valid !== 1'b0)    begin failures++; $display("FAIL rst_valid: got %b want 0", o_valid); end
    if (o_data !== '0)       begin failures++; $display("FAIL rst_data: got %h want 0", o_data); end
    if (o_hdr_err !== 1'b0)  begin failures++; $display("FAIL rst_hdr_err: got %b want 0", o_hdr_err); end
    if (o_lock !== 1'b0)     begin failures++; $display("FAIL rst_lock: got %b want 0", o_lock); end
    if (o_block_cnt !== '0)  begin failures++; $display("FAIL rst_block_cnt: got %h want 0", o_block_cnt); end
    if (o_err_cnt !== '0)    begin failures++; $display("FAIL rst_err_cnt: got %h want 0", o_err_cnt); end
    i_valid   = 1'b0;
    rst_n     = 1'b1;
    tb_synced = 1'b0;
    send(mk_block(2));
    checks += 3;
    if (o_hdr_err !== 1'b0)  begin failures++; $display("FAIL unsync_hdr_err: got %b want 0", o_hdr_err); end
    if (o_err_cnt !== '0)    begin failures++; $display("FAIL unsync_err_cnt: got %h want 0", o_err_cnt); end
    if (o_block_cnt !== '0)  begin failures++; $display("FAIL unsync_block_cnt: got %h want 0", o_block_cnt); end
  endtask

  task automatic test_lock_acquire();
    do_reset();
    feed(64, 0);
    checks++;
    if (o_lock !== 1'b0) begin failures++; $display("FAIL acq_early_lock: got %b want 0", o_lock); end
    feed(1, 0);
    checks++;
    if (o_lock !== 1'b1) begin failures++; $display("FAIL acq_lock: got %b want 1", o_lock); end
    feed(15, 0);
    checks += 3;
    if (o_lock !== 1'b1)            begin failures++; $display("FAIL acq_hold: got %b want 1", o_lock); end
    if (o_err_cnt !== 32'd0)        begin failures++; $display("FAIL acq_err_cnt: got %0d want 0", o_err_cnt); end
    if (o_block_cnt !== 32'd15)     begin failures++; $display("FAIL acq_block_cnt: got %0d want 15", o_block_cnt); end
  endtask

  task automatic test_lock_loss();
    do_reset();
    feed(65, 1);
    for (int i = 0; i < 40; i++) feed(1, (i < 30 && i % 2 == 0) ? 2 : 1);
    checks += 3;
    if (o_lock !== 1'b1)        begin failures++; $display("FAIL loss_hold: got %b want 1", o_lock); end
    if (o_err_cnt !== 32'd15)   begin failures++; $display("FAIL loss_err15: got %0d want 15", o_err_cnt); end
    if (o_block_cnt !== 32'd40) begin failures++; $display("FAIL loss_blk40: got %0d want 40", o_block_cnt); end
    feed(1, 2);
    checks += 2;
    if (o_lock !== 1'b0)        begin failures++; $display("FAIL loss_drop: got %b want 0", o_lock); end
    if (o_err_cnt !== 32'd16)   begin failures++; $display("FAIL loss_err16: got %0d want 16", o_err_cnt); end
    feed(1, 1);
    checks++;
    if (o_block_cnt !== 32'd41) begin failures++; $display("FAIL loss_blk_unlocked: got %0d want 41", o_block_cnt); end
  endtask

  task automatic test_window_wrap();
    do_reset();
    feed(65, 1);
    feed(15, 2);
    feed(49, 1);
    feed(15, 2);
    checks += 2;
    if (o_lock !== 1'b1)        begin failures++; $display("FAIL wrap_hold: got %b want 1", o_lock); end
    if (o_err_cnt !== 32'd30)   begin failures++; $display("FAIL wrap_err_cnt: got %0d want 30", o_err_cnt); end
  endtask

  task automatic test_good_restart();
    do_reset();
    feed(64, 1);
    feed(1, 2);
    feed(63, 1);
    checks++;
    if (o_lock !== 1'b0) begin failures++; $display("FAIL restart_early: got %b want 0", o_lock); end
    feed(1, 1);
    checks++;
    if (o_lock !== 1'b1) begin failures++; $display("FAIL restart_lock: got %b want 1", o_lock); end
  endtask

  task automatic test_saturate_clear();
    do_reset();
    feed(65, 1);
    force dut.o_block_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.o_block_cnt;
    feed(3, 1);
    checks++;
    if (o_block_cnt !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_block_cnt: got %h want ffffffff", o_block_cnt); end
    feed(1, 2);
    checks++;
    if (o_err_cnt !== 32'd1) begin failures++; $display("FAIL pre_clr_err: got %0d want 1", o_err_cnt); end
    i_clr_cnt = 1'b1;
    feed(1, 2);
    i_clr_cnt = 1'b0;
    checks += 2;
    if (o_block_cnt !== 32'd0) begin failures++; $display("FAIL clr_block_cnt: got %0d want 0", o_block_cnt); end
    if (o_err_cnt !== 32'd0)   begin failures++; $display("FAIL clr_err_cnt: got %0d want 0", o_err_cnt); end
    feed(1, 1);
    checks++;
    if (o_block_cnt !== 32'd1) begin failures++; $display("FAIL post_clr_block_cnt: got %0d want 1", o_block_cnt); end
  endtask

  task automatic test_toggle_valid();
    do_reset();
    feed(1, 1);
    idle();
    for (int i = 0; i < 64; i++) begin
      if (i == 63) begin
        checks++;
        if (o_lock !== 1'b0) begin failures++; $display("FAIL toggle_early: got %b want 0", o_lock); end
      end
      feed(1, 1);
      idle();
      checks += 2;
      if (o_valid !== 1'b0)        begin failures++; $display("FAIL toggle_valid_low: got %b want 0", o_valid); end
      if (o_data !== last_payload) begin failures++; $display("FAIL toggle_data_hold: got %h want %h", o_data, last_payload); end
    end
    checks++;
    if (o_lock !== 1'b1) begin failures++; $display("FAIL toggle_lock: got %b want 1", o_lock); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    feed(70, 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (o_lock !== 1'b0)        begin failures++; $display("FAIL mid_lock: got %b want 0", o_lock); end
    if (o_valid !== 1'b0)       begin failures++; $display("FAIL mid_valid: got %b want 0", o_valid); end
    if (o_data !== '0)          begin failures++; $display("FAIL mid_data: got %h want 0", o_data); end
    if (o_block_cnt !== 32'd0)  begin failures++; $display("FAIL mid_block_cnt: got %0d want 0", o_block_cnt); end
    #2;
    rst_n     = 1'b1;
    tb_synced = 1'b0;
    feed(64, 1);
    checks++;
    if (o_lock !== 1'b0) begin failures++; $display("FAIL mid_relock_early: got %b want 0", o_lock); end
    feed(1, 1);
    checks++;
    if (o_lock !== 1'b1) begin failures++; $display("FAIL mid_relock: got %b want 1", o_lock); end
  endtask

  initial begin
    tx_sh       = {26'($urandom), $urandom};
    tb_synced   = 1'b0;
    i_scrambler = '0;
    last_payload = '0;
    test_reset();
    test_lock_acquire();
    test_lock_loss();
    test_window_wrap();
    test_good_restart();
    test_saturate_clear();
    test_toggle_valid();
    test_reset_midstream();
    idle();
    idle();
    checks++;
    if (sbq.size() != 0) begin failures++; $display("FAIL sb_leftover: got %0d pending want 0", sbq.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
